video_pattern_generator: RTL

- Parametrised, mode-selectable test-pattern source for the HDMI/DVI video path.
- Sits between the video signal generator (screen coordinates, syncs, DE, new-frame pulse) and the per-channel TMDS encoders.
- Replaces a hard-coded static square with five runtime-selectable patterns, including a frame-animated bouncing square.
- Fixed two-cycle pipeline, with syncs and DE delay-matched to the colour outputs.

---
 rtl/video_pattern_generator.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_generator.sv
// Test-pattern source for the HDMI/DVI path: five frame-latched patterns over a
// fixed two-stage pipeline, with DE and syncs delayed to line up with the colour.
module video_pattern_generator #(
  parameter int COORD_BITS  = 10,
  parameter int COLOUR_BITS = 4,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SQ_SIZE     = 200,
  parameter int SQ_X0       = 220,
  parameter int SQ_Y0       = 140,
  parameter int SPEED       = 2,
  parameter int CHECK_LOG2  = 5
) (
  input  logic                   i_clk_pxl,
  input  logic                   i_rst_n,
  input  logic [COORD_BITS-1:0]  i_sx,
  input  logic [COORD_BITS-1:0]  i_sy,
  input  logic                   i_de,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_nf,
  input  logic [2:0]             i_mode,
  output logic [COLOUR_BITS-1:0] o_r,
  output logic [COLOUR_BITS-1:0] o_g,
  output logic [COLOUR_BITS-1:0] o_b,
  output logic                   o_de,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [2:0]             o_mode
);

  localparam int CW = COORD_BITS + 1;
  typedef logic [CW-1:0] wide_t;

  localparam wide_t X_LIM = wide_t'(H_RES - SQ_SIZE);
  localparam wide_t Y_LIM = wide_t'(V_RES - SQ_SIZE);
  localparam wide_t SPD   = wide_t'(SPEED);
  localparam wide_t SQ    = wide_t'(SQ_SIZE);
  localparam wide_t SX0   = wide_t'(SQ_X0);
  localparam wide_t SY0   = wide_t'(SQ_Y0);

  localparam int                    BAR_W    = H_RES / 8;
  localparam logic [COORD_BITS-1:0] BAR_LAST = COORD_BITS'(BAR_W - 1);

  localparam logic [COLOUR_BITS-1:0] BG_R = COLOUR_BITS'(1);
  localparam logic [COLOUR_BITS-1:0] BG_G = COLOUR_BITS'(3);
  localparam logic [COLOUR_BITS-1:0] BG_B = COLOUR_BITS'(7);

  localparam logic [2:0] M_STATIC = 3'd1;
  localparam logic [2:0] M_BOUNCE = 3'd2;
  localparam logic [2:0] M_BARS   = 3'd3;
  localparam logic [2:0] M_CHECK  = 3'd4;

  typedef enum logic [1:0] {K_BG, K_WHITE, K_BLACK, K_BAR} kind_e;

  logic [2:0]             mode_q, mode_d;
  logic [COORD_BITS-1:0]  px_q, px_d, py_q, py_d;
  logic                   dx_q, dx_d, dy_q, dy_d;
  logic [COORD_BITS-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]             bar_idx_q, bar_idx_d;
  kind_e                  s1_kind_q, s1_kind_d;
  logic [2:0]             s1_bar_q, s1_bar_d;
  logic                   s1_de_q, s1_hs_q, s1_vs_q;
  logic [COLOUR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   de_q, hs_q, vs_q;

  // Returns {new_dir, new_pos}; dir 1 means moving towards zero.
  function automatic logic [COORD_BITS:0] step_axis(input logic [COORD_BITS-1:0] pos,
                                                    input logic dir_neg,
                                                    input wide_t lim);
    wide_t p;
    wide_t sum;
    wide_t dif;
    p   = {1'b0, pos};
    sum = p + SPD;
    dif = p - SPD;
    if (!dir_neg) begin
      if (sum >= lim) step_axis = {1'b1, lim[COORD_BITS-1:0]};
      else            step_axis = {1'b0, sum[COORD_BITS-1:0]};
    end else begin
      if (p <= SPD)   step_axis = {1'b0, {COORD_BITS{1'b0}}};
      else            step_axis = {1'b1, dif[COORD_BITS-1:0]};
    end
  endfunction

  // Mode latch and square motion; the motion test looks at i_mode so a switch
  // into bounce mode steps on the same new-frame pulse.
  always_comb begin
    mode_d = mode_q;
    px_d   = px_q;
    py_d   = py_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    if (i_nf) begin
      mode_d = i_mode;
      if (i_mode == M_BOUNCE) begin
        {dx_d, px_d} = step_axis(px_q, dx_q, X_LIM);
        {dy_d, py_d} = step_axis(py_q, dy_q, Y_LIM);
      end
    end
  end

  logic [COORD_BITS-1:0] cnt_base;
  logic [2:0]            idx_cur;

  always_comb begin
    cnt_base  = (i_sx == '0) ? '0 : bar_cnt_q;
    idx_cur   = (i_sx == '0) ? 3'd0 : bar_idx_q;
    bar_cnt_d = cnt_base;
    bar_idx_d = idx_cur;
    if (i_de) begin
      if (cnt_base == BAR_LAST) begin
        bar_cnt_d = '0;
        if (idx_cur != 3'd7) bar_idx_d = idx_cur + 3'd1;
      end else begin
        bar_cnt_d = cnt_base + 1'b1;
      end
    end
  end

  wide_t sxw, syw, pxw, pyw;
  logic  in_static, in_bounce, check_on;

  always_comb begin
    sxw       = {1'b0, i_sx};
    syw       = {1'b0, i_sy};
    pxw       = {1'b0, px_q};
    pyw       = {1'b0, py_q};
    in_static = (sxw > SX0) && (sxw < SX0 + SQ) && (syw > SY0) && (syw < SY0 + SQ);
    in_bounce = (sxw > pxw) && (sxw < pxw + SQ) && (syw > pyw) && (syw < pyw + SQ);
    check_on  = i_sx[CHECK_LOG2] ^ i_sy[CHECK_LOG2];
    s1_bar_d  = idx_cur;
    case (mode_q)
      M_STATIC: s1_kind_d = in_static ? K_WHITE : K_BG;
      M_BOUNCE: s1_kind_d = in_bounce ? K_WHITE : K_BG;
      M_BARS:   s1_kind_d = K_BAR;
      M_CHECK:  s1_kind_d = check_on ? K_WHITE : K_BLACK;
      default:  s1_kind_d = K_BG;
    endcase
  end

  // Bar index bits map directly onto channels: white,yellow,cyan,green,magenta,red,blue,black.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (s1_kind_q)
      K_BG:    begin r_d = BG_R; g_d = BG_G; b_d = BG_B; end
      K_WHITE: begin r_d = '1; g_d = '1; b_d = '1; end
      K_BAR: begin
        r_d = {COLOUR_BITS{~s1_bar_q[1]}};
        g_d = {COLOUR_BITS{~s1_bar_q[2]}};
        b_d = {COLOUR_BITS{~s1_bar_q[0]}};
      end
      default: begin r_d = '0; g_d = '0; b_d = '0; end
    endcase
    if (!s1_de_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge i_clk_pxl or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q    <= '0;
      px_q      <= COORD_BITS'(SQ_X0);
      py_q      <= COORD_BITS'(SQ_Y0);
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      s1_kind_q <= K_BG;
      s1_bar_q  <= '0;
      s1_de_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      px_q      <= px_d;
      py_q      <= py_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      s1_kind_q <= s1_kind_d;
      s1_bar_q  <= s1_bar_d;
      s1_de_q   <= i_de;
      s1_hs_q   <= i_hsync;
      s1_vs_q   <= i_vsync;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      de_q      <= s1_de_q;
      hs_q      <= s1_hs_q;
      vs_q      <= s1_vs_q;
    end
  end

  assign o_r     = r_q;
  assign o_g     = g_q;
  assign o_b     = b_q;
  assign o_de    = de_q;
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_mode  = mode_q;

endmodule
